mem_power_monitor: RTL and testbench
====================================

# mem_power_monitor

Parametrised supply monitor for embedded memory macros. It watches NUM_DOM independent VDD/VSS rail pairs, debounces power-up, and reports per-domain power-good. It emits single-cycle corrupt requests to the memory array and output stage whenever a good supply becomes invalid, and keeps sticky per-rail error flags plus saturating fault counters. It sits between the power-aware memory wrapper and the macro's corrupt tasks/ports, and replaces the single-domain, unclocked VDD/VSS check.

## Interface
- NUM_DOM, 4: number of independent supply domains (≥1).
- DEB_CYC, 8: consecutive valid samples required before power-good (≥1).
- CNT_W, 8: width of each per-domain fault counter.
- clk  in  1  monitor clock.
- rst  in  1  asynchronous, active-high reset.
- vdd  in  NUM_DOM  VDD level per domain; valid only when 1.
- vss  in  NUM_DOM  VSS level per domain; valid only when 0.
- msg_level  in  2  message control; errors reported when msg_level ≥ MSG_ERROR (2).
- clear_err  in  1  synchronous clear of sticky flags and fault counters.
- power_good  out  NUM_DOM  domain debounced and valid.
- corrupt_mem  out  NUM_DOM  1-cycle pulse: corrupt memory contents to X.
- corrupt_out  out  NUM_DOM  1-cycle pulse: corrupt output data to X.
- err_vdd, err_vss  out  NUM_DOM each  sticky: rail seen invalid while GOOD.
- fault_cnt  out  NUM_DOM*CNT_W  per-domain GOOD→FAULT count, domain d at [d*CNT_W +: CNT_W].
- err_irq  out  1  registered OR of this-cycle corrupt pulses, gated by msg_level ≥ 2.

## Operation
- Per domain: supply_ok = (vdd==1 && vss==0). Any X/Z or wrong level counts as not ok.
- States: DOWN, UP_DEB, GOOD, FAULT. Reset state is DOWN with deb_cnt = 0.
- DOWN: supply_ok → UP_DEB, deb_cnt=0. Otherwise stay.
- UP_DEB: !supply_ok → DOWN, deb_cnt=0. supply_ok && deb_cnt==DEB_CYC-1 → GOOD. Otherwise deb_cnt++.
- GOOD: power_good=1. !supply_ok → FAULT. On that transition:
  - pulse corrupt_mem and corrupt_out for one cycle.
  - set err_vdd if vdd!=1; set err_vss if vss!=0. Both can be set.
  - fault_cnt increments and saturates at 2^CNT_W−1.
- FAULT: power_good=0. supply_ok → UP_DEB, deb_cnt=0. No further pulses while remaining in FAULT.
- clear_err zeroes err_vdd, err_vss and fault_cnt. If clear_err coincides with a new fault, the new fault wins: flags set and fault_cnt=1.
- Domains are fully independent. Simultaneous faults in several domains pulse each domain's bits in the same cycle.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Inputs are sampled on the rising edge of clk. The caller synchronises asynchronous rails externally.
- power_good rises exactly DEB_CYC+1 edges after the first edge that samples supply_ok, given continuous validity.
- The corrupt pulse and power_good fall appear in the cycle after the first invalid sample; latency is 1.
- err_irq asserts one cycle after the corrupt pulse, for 1 cycle.
- rst mid-operation: outputs drop to 0 asynchronously. FSM returns to DOWN, counters clear, and no corrupt pulse is generated.
- DEB_CYC=1: DOWN→UP_DEB→GOOD takes two valid samples.

## Structure
- Package mem_pwr_pkg holds:
  - pwr_state_e {DOWN, UP_DEB, GOOD, FAULT}.
  - MSG_ERROR=2, and message levels NONE/WARN/ERROR/DEBUG = 0..3.
- Sub-module mem_pwr_dom_fsm: one domain's FSM, debounce counter, sticky flags and saturating counter. It is instantiated NUM_DOM times by generate.
- The top level only adds err_irq reduction and output packing.

## Test plan
- Power-up, DEB_CYC=8: vdd=1, vss=0 from cycle 0 → power_good[0] rises at edge 9. All other outputs stay 0.
- Glitch during debounce: valid 5 cycles, vdd=0 for 1 cycle, then valid → return to DOWN. power_good rises 9 edges after re-valid. No corrupt pulse.
- Fault in GOOD with msg_level=2: vss→1 on domain 2 → corrupt_mem[2] and corrupt_out[2] pulse 1 cycle, err_vss[2]=1, fault_cnt[2]=1, err_irq pulses next cycle. With msg_level=1, err_irq stays 0.
- Saturation, CNT_W=2: 5 GOOD→FAULT cycles → fault_cnt=3. clear_err → 0.
- Simultaneous: domains 0 and 3 both lose vdd in the same cycle → both corrupt bits pulse together. err_vdd=4'b1001.
- Async reset while GOOD and faulting: assert rst mid-cycle → all outputs 0 immediately. After release with rails valid, power_good returns after DEB_CYC+1 edges.

Source files
------------

// File: rtl/mem_pwr_pkg.sv
// Shared types for the memory supply monitor: per-domain power state and message levels.
package mem_pwr_pkg;

    typedef enum logic [1:0] {
        DOWN   = 2'd0,
        UP_DEB = 2'd1,
        GOOD   = 2'd2,
        FAULT  = 2'd3
    } pwr_state_e;

    typedef enum logic [1:0] {
        MSG_NONE  = 2'd0,
        MSG_WARN  = 2'd1,
        MSG_ERROR = 2'd2,
        MSG_DEBUG = 2'd3
    } msg_level_e;

    // Debounce counter width; a single-cycle debounce still needs one bit.
    function automatic int unsigned deb_width(input int unsigned cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/mem_pwr_dom_fsm.sv
// One supply domain: debounce FSM, single-cycle corrupt pulse on GOOD->FAULT,
// sticky per-rail error flags and a saturating fault counter.
module mem_pwr_dom_fsm
    import mem_pwr_pkg::*;
#(
    parameter int unsigned DEB_CYC = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vdd,
    input  logic             vss,
    input  logic             clear_err,
    output logic             power_good,
    output logic             corrupt,
    output logic             err_vdd,
    output logic             err_vss,
    output logic [CNT_W-1:0] fault_cnt
);

    localparam int unsigned      DEB_W    = deb_width(DEB_CYC);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    pwr_state_e       state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             power_good_q, power_good_d;
    logic             corrupt_q, corrupt_d;
    logic             err_vdd_q, err_vdd_d;
    logic             err_vss_q, err_vss_d;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;

    logic vdd_ok, vss_ok, supply_ok, fault_now;

    // Written as if/else so an unknown rail level resolves to "not ok".
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
        vdd_ok = 1'b0;
        vss_ok = 1'b0;
        if (vdd == 1'b1) vdd_ok = 1'b1;
        if (vss == 1'b0) vss_ok = 1'b1;
        supply_ok = vdd_ok && vss_ok;
    end

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        fault_now = 1'b0;

        case (state_q)
            DOWN: begin
                if (supply_ok) begin
                    state_d   = UP_DEB;
                    deb_cnt_d = '0;
                end
            end
            UP_DEB: begin
                if (!supply_ok) begin
                    state_d   = DOWN;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = GOOD;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            GOOD: begin
                if (!supply_ok) begin
                    state_d   = FAULT;
                    fault_now = 1'b1;
                end
            end
            FAULT: begin
                if (supply_ok) begin
                    state_d   = UP_DEB;
                    deb_cnt_d = '0;
                end
            end
            default: state_d = DOWN;
        endcase

        power_good_d = (state_d == GOOD);
        corrupt_d    = fault_now;

        err_vdd_d   = err_vdd_q;
        err_vss_d   = err_vss_q;
        fault_cnt_d = fault_cnt_q;
        if (clear_err) begin
            err_vdd_d   = 1'b0;
            err_vss_d   = 1'b0;
            fault_cnt_d = '0;
        end
        // Applied after the clear so a coincident fault survives it with a count of one.
        if (fault_now) begin
            if (!vdd_ok) err_vdd_d = 1'b1;
            if (!vss_ok) err_vss_d = 1'b1;
            if (fault_cnt_d != CNT_MAX) fault_cnt_d = fault_cnt_d + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= DOWN;
            deb_cnt_q    <= '0;
            power_good_q <= 1'b0;
            corrupt_q    <= 1'b0;
            err_vdd_q    <= 1'b0;
            err_vss_q    <= 1'b0;
            fault_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            power_good_q <= power_good_d;
            corrupt_q    <= corrupt_d;
            err_vdd_q    <= err_vdd_d;
            err_vss_q    <= err_vss_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    assign power_good = power_good_q;
    assign corrupt    = corrupt_q;
    assign err_vdd    = err_vdd_q;
    assign err_vss    = err_vss_q;
    assign fault_cnt  = fault_cnt_q;

endmodule

// File: rtl/mem_power_monitor.sv
// Multi-domain supply monitor for memory macros: one FSM per VDD/VSS pair,
// plus a registered error interrupt gated by the message level.
module mem_power_monitor
    import mem_pwr_pkg::*;
#(
    parameter int unsigned NUM_DOM = 4,
    parameter int unsigned DEB_CYC = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_DOM-1:0]       vdd,
    input  logic [NUM_DOM-1:0]       vss,
    input  logic [1:0]               msg_level,
    input  logic                     clear_err,
    output logic [NUM_DOM-1:0]       power_good,
    output logic [NUM_DOM-1:0]       corrupt_mem,
    output logic [NUM_DOM-1:0]       corrupt_out,
    output logic [NUM_DOM-1:0]       err_vdd,
    output logic [NUM_DOM-1:0]       err_vss,
    output logic [NUM_DOM*CNT_W-1:0] fault_cnt,
    output logic                     err_irq
);

    logic [NUM_DOM-1:0] corrupt;
    logic               err_irq_q, err_irq_d;

    for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
        mem_pwr_dom_fsm #(
            .DEB_CYC (DEB_CYC),
            .CNT_W   (CNT_W)
        ) u_dom (
            .clk        (clk),
            .rst        (rst),
            .vdd        (vdd[d]),
            .vss        (vss[d]),
            .clear_err  (clear_err),
            .power_good (power_good[d]),
            .corrupt    (corrupt[d]),
            .err_vdd    (err_vdd[d]),
            .err_vss    (err_vss[d]),
            .fault_cnt  (fault_cnt[d*CNT_W +: CNT_W])
        );
    end

    // Memory and output-stage corruption are requested by the same registered pulse.
    assign corrupt_mem = corrupt;
    assign corrupt_out = corrupt;

    always_comb begin
        err_irq_d = (|corrupt) && (msg_level >= MSG_ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_irq_q <= 1'b0;
        end else begin
            err_irq_q <= err_irq_d;
        end
    end

    assign err_irq = err_irq_q;

endmodule

// File: tb/tb_mem_power_monitor.sv
// Scoreboard bench for mem_power_monitor: a run-length reference model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_mem_power_monitor;

    localparam int NUM_DOM = 4;
    localparam int DEB_CYC = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NUM_DOM-1:0]       vdd = '0;
    logic [NUM_DOM-1:0]       vss = '0;
    logic [1:0]               msg_level = 2'd0;
    logic                     clear_err = 1'b0;
    logic [NUM_DOM-1:0]       power_good, corrupt_mem, corrupt_out, err_vdd, err_vss;
    logic [NUM_DOM*CNT_W-1:0] fault_cnt;
    logic                     err_irq;

    mem_power_monitor #(
        .NUM_DOM (NUM_DOM),
        .DEB_CYC (DEB_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vdd         (vdd),
        .vss         (vss),
        .msg_level   (msg_level),
        .clear_err   (clear_err),
        .power_good  (power_good),
        .corrupt_mem (corrupt_mem),
        .corrupt_out (corrupt_out),
        .err_vdd     (err_vdd),
        .err_vss     (err_vss),
        .fault_cnt   (fault_cnt),
        .err_irq     (err_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_DOM-1:0]       pg;
        logic [NUM_DOM-1:0]       cm;
        logic [NUM_DOM-1:0]       co;
        logic [NUM_DOM-1:0]       ev;
        logic [NUM_DOM-1:0]       es;
        logic [NUM_DOM*CNT_W-1:0] cnt;
        logic                     irq;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model: a domain is good once it has seen DEB_CYC+1 consecutive valid samples.
    int                 run_m [NUM_DOM];
    int                 cnt_m [NUM_DOM];
    logic [NUM_DOM-1:0] ev_m, es_m, corrupt_m;

    function automatic obs_t sample();
        obs_t o;
        o.pg  = power_good;
        o.cm  = corrupt_mem;
        o.co  = corrupt_out;
        o.ev  = err_vdd;
        o.es  = err_vss;
        o.cnt = fault_cnt;
        o.irq = err_irq;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got pg=%b cm=%b co=%b ev=%b es=%b cnt=%h irq=%b, expected pg=%b cm=%b co=%b ev=%b es=%b cnt=%h irq=%b",
                     name, got.pg, got.cm, got.co, got.ev, got.es, got.cnt, got.irq,
                     exp.pg, exp.cm, exp.co, exp.ev, exp.es, exp.cnt, exp.irq);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NUM_DOM; d++) begin
            run_m[d] = 0;
            cnt_m[d] = 0;
        end
        ev_m      = '0;
        es_m      = '0;
        corrupt_m = '0;
    endtask

    // Called at each rising edge with the inputs the DUT just sampled.
    task automatic model_edge();
        obs_t e;
        logic any_prev;
        logic good_prev, ok, fault;
        any_prev = |corrupt_m;
        e = '0;
        for (int d = 0; d < NUM_DOM; d++) begin
            good_prev = (run_m[d] > DEB_CYC);
            ok        = vdd[d] && !vss[d];
            if (!ok) run_m[d] = 0;
            else if (run_m[d] <= DEB_CYC) run_m[d] = run_m[d] + 1;
            fault        = good_prev && !ok;
            corrupt_m[d] = fault;
            if (clear_err) begin
                ev_m[d]  = 1'b0;
                es_m[d]  = 1'b0;
                cnt_m[d] = 0;
            end
            if (fault) begin
                if (!vdd[d]) ev_m[d] = 1'b1;
                if (vss[d])  es_m[d] = 1'b1;
                if (cnt_m[d] < CNT_MAX) cnt_m[d] = cnt_m[d] + 1;
            end
            e.pg[d] = (run_m[d] > DEB_CYC);
            e.cnt[d*CNT_W +: CNT_W] = CNT_W'(cnt_m[d]);
        end
        e.cm  = corrupt_m;
        e.co  = corrupt_m;
        e.ev  = ev_m;
        e.es  = es_m;
        e.irq = any_prev && (msg_level >= 2'd2);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [NUM_DOM-1:0] v, input logic [NUM_DOM-1:0] s,
                        input logic [1:0] m, input logic clr);
        @(negedge clk);
        rst       = 1'b0;
        vdd       = v;
        vss       = s;
        msg_level = m;
        clear_err = clr;
        @(posedge clk);
        model_edge();
        cyc++;
    endtask

    // Asserts reset between edges; it is released by the next step.
    task automatic async_reset();
        obs_t zero;
        zero = '0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        check("async reset", sample(), zero);
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("cycle %0d", cyc), sample(), e);
            end
        end
    end

    initial begin : stimulus
        logic [NUM_DOM-1:0] v, s;
        model_reset();
        async_reset();

        repeat (12) step(4'b0001, 4'b0000, 2'd2, 1'b0);          // domain 0 power-up
        repeat (5)  step(4'b0011, 4'b0000, 2'd2, 1'b0);          // domain 1 glitch
        step(4'b0001, 4'b0000, 2'd2, 1'b0);
        repeat (10) step(4'b0011, 4'b0000, 2'd2, 1'b0);
        repeat (10) step(4'b1111, 4'b0000, 2'd2, 1'b0);
        repeat (3)  step(4'b1111, 4'b0100, 2'd2, 1'b0);          // vss fault, irq enabled
        repeat (10) step(4'b1111, 4'b0000, 2'd2, 1'b0);
        repeat (3)  step(4'b1111, 4'b0100, 2'd1, 1'b0);          // vss fault, irq masked
        repeat (10) step(4'b1111, 4'b0000, 2'd1, 1'b0);
        repeat (5) begin                                          // counter saturation
            step(4'b1111, 4'b0100, 2'd2, 1'b0);
            repeat (9) step(4'b1111, 4'b0000, 2'd2, 1'b0);
        end
        step(4'b1111, 4'b0000, 2'd2, 1'b1);
        repeat (2)  step(4'b0110, 4'b0000, 2'd2, 1'b0);          // domains 0 and 3 together
        repeat (10) step(4'b1111, 4'b0000, 2'd2, 1'b0);
        step(4'b1111, 4'b0001, 2'd2, 1'b1);                       // clear coincides with fault
        repeat (10) step(4'b1111, 4'b0000, 2'd2, 1'b0);
        step(4'b1110, 4'b0000, 2'd2, 1'b0);                       // reset while faulting
        async_reset();
        repeat (12) step(4'b1111, 4'b0000, 2'd2, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < NUM_DOM; d++) begin
                v[d] = 1'b1;
                s[d] = 1'b0;
                if ($urandom_range(0, 99) >= 94) begin
                    case ($urandom_range(0, 2))
                        0:       v[d] = 1'b0;
                        1:       s[d] = 1'b1;
                        default: begin v[d] = 1'b0; s[d] = 1'b1; end
                    endcase
                end
            end
            step(v, s, 2'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0));
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
